// File: rtl/key_seq_initiator.sv
// key_seq_initiator: bus-side initiator for the address-encoded serial key protocol.
// Issues SEQ_LEN qualified read cycles and assembles the sampled SDRD bits.
module key_seq_initiator #(
    parameter int SEQ_LEN       = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [4*SEQ_LEN-1:0]   challenge,
    input  logic                   sdrd,
    output logic                   sser_n,
    output logic                   ba13,
    output logic                   ba12,
    output logic [3:0]             ba_nib,
    output logic                   br_w,
    output logic                   busy,
    output logic                   done,
    output logic [SEQ_LEN-1:0]     response
);

    localparam int IW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int CMAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(SEQ_LEN - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP,
        FINISH
    } state_t;

    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [4*SEQ_LEN-1:0] chal, chal_n;
    logic [SEQ_LEN-1:0]   resp_n;
    logic                 step;
    logic                 on_bus;
    logic [3:0]           nib_n;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        chal_n  = chal;
        resp_n  = response;
        step    = 1'b0;
        if (abort && state != IDLE) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        chal_n  = challenge;
                        resp_n  = '0;
                        idx_n   = '0;
                        state_n = SETUP;
                    end
                end
                SETUP: begin
                    cnt_n   = '0;
                    state_n = STROBE;
                end
                STROBE: begin
                    if (cnt == STB_LAST) begin
                        resp_n[idx] = sdrd;
                        cnt_n       = '0;
                        if (GAP_CYCLES > 0) state_n = GAP;
                        else step = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n = '0;
                        step  = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                FINISH: state_n = IDLE;
                default: state_n = IDLE;
            endcase
            // Advance to the next bus cycle, or wrap up without overrunning idx
            if (step) begin
                if (idx == IDX_LAST) begin
                    state_n = FINISH;
                end else begin
                    idx_n   = idx + IW'(1);
                    state_n = SETUP;
                end
            end
        end
        on_bus = (state_n == SETUP) || (state_n == STROBE) || (state_n == GAP);
        nib_n  = on_bus ? chal_n[{idx_n, 2'b00} +: 4] : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            chal     <= '0;
            response <= '0;
            sser_n   <= 1'b1;
            ba13     <= 1'b0;
            ba12     <= 1'b0;
            ba_nib   <= 4'h0;
            br_w     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            chal     <= chal_n;
            response <= resp_n;
            sser_n   <= (state_n != STROBE);
            ba13     <= 1'b0;
            ba12     <= on_bus;
            ba_nib   <= nib_n;
            br_w     <= on_bus;
            busy     <= (state_n != IDLE);
            done     <= (state_n == FINISH);
        end
    end

endmodule

// File: tb/tb_key_seq_initiator.sv
// tb_key_seq_initiator: randomized bench with a timeline-based reference model.
// Two instances: default parameters and SEQ_LEN=4/STROBE=1/GAP=0.
module tb_key_seq_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st [2];
    logic        ab [2];
    logic        sd [2];
    logic [63:0] ch [2];

    logic        so [2];
    logic        b13 [2];
    logic        b12 [2];
    logic        bw [2];
    logic        bz [2];
    logic        dn [2];
    logic [3:0]  nb [2];
    logic [15:0] rs0;
    logic [3:0]  rs1;
    logic [15:0] rsp [2];

    assign rsp[0] = rs0;
    assign rsp[1] = {12'h000, rs1};

    key_seq_initiator u0 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
        .challenge(ch[0]), .sdrd(sd[0]),
        .sser_n(so[0]), .ba13(b13[0]), .ba12(b12[0]), .ba_nib(nb[0]),
        .br_w(bw[0]), .busy(bz[0]), .done(dn[0]), .response(rs0)
    );

    key_seq_initiator #(.SEQ_LEN(4), .STROBE_CYCLES(1), .GAP_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
        .challenge(ch[1][15:0]), .sdrd(sd[1]),
        .sser_n(so[1]), .ba13(b13[1]), .ba12(b12[1]), .ba_nib(nb[1]),
        .br_w(bw[1]), .busy(bz[1]), .done(dn[1]), .response(rs1)
    );

    int pl [2] = '{16, 4};
    int ps [2] = '{2, 1};
    int pg [2] = '{1, 0};

    function automatic int per(input int i);
        return 1 + ps[i] + pg[i];
    endfunction

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, i, a, e, $time);
        end
    endtask

    // Reference model: edges elapsed since acceptance define every output.
    bit          act [2];
    int          k [2];
    logic [63:0] mchal [2];
    logic [15:0] mresp [2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 1'b0; k[i] = 0; mchal[i] = '0; mresp[i] = '0;
            end else if (!act[i]) begin
                if (st[i] && !ab[i]) begin
                    act[i] = 1'b1; k[i] = 0; mchal[i] = ch[i]; mresp[i] = '0;
                end
            end else if (ab[i]) begin
                act[i] = 1'b0;
            end else begin
                k[i]++;
                if (k[i] <= pl[i] * per(i) && (k[i] - 1) % per(i) == ps[i])
                    mresp[i][(k[i] - 1) / per(i)] = sd[i];
                if (k[i] == pl[i] * per(i) + 1) act[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic es, e12, ebz, edn;
            logic [3:0] en;
            int p, ph, g;
            p = per(i);
            es = 1'b1; e12 = 1'b0; ebz = 1'b0; edn = 1'b0; en = 4'h0;
            if (act[i]) begin
                ebz = 1'b1;
                if (k[i] < pl[i] * p) begin
                    ph  = k[i] % p;
                    g   = k[i] / p;
                    es  = !(ph >= 1 && ph <= ps[i]);
                    e12 = 1'b1;
                    en  = 4'(mchal[i] >> (4 * g));
                end else begin
                    edn = 1'b1;
                end
            end
            chk("sser_n", i, 64'(so[i]), 64'(es));
            chk("ba13", i, 64'(b13[i]), 64'h0);
            chk("ba12", i, 64'(b12[i]), 64'(e12));
            chk("br_w", i, 64'(bw[i]), 64'(e12));
            chk("ba_nib", i, 64'(nb[i]), 64'(en));
            chk("busy", i, 64'(bz[i]), 64'(ebz));
            chk("done", i, 64'(dn[i]), 64'(edn));
            chk("response", i, 64'(rsp[i]), 64'(mresp[i]));
        end
    end

    // sdrd source: 0 = tied high, 1 = pattern bit per bus cycle, 2 = random
    int          sdmode = 0;
    logic [15:0] pat = 16'hA5C3;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int g;
            g = (act[i] && k[i] < pl[i] * per(i)) ? k[i] / per(i) : 0;
            case (sdmode)
                0: sd[i] = 1'b1;
                1: sd[i] = pat[g];
                default: sd[i] = 1'($urandom);
            endcase
        end
    end

    logic [63:0] nibs;

    task automatic run_seq(input int i, input bit repulse, output int n);
        logic prev;
        prev = 1'b1;
        nibs = '0;
        n = 0;
        st[i] = 1'b1;
        @(posedge clk);
        n = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            st[i] = (repulse && n == 20);
            if (repulse && n == 20) ch[i] = {$urandom, $urandom};
            if (!so[i] && prev) nibs = {nibs[59:0], nb[i]};
            prev = so[i];
            if (dn[i]) break;
            @(posedge clk);
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; ch[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        ch[0] = 64'h0123456789ABCDEF;
        sdmode = 0;
        run_seq(0, 1'b1, n);
        chk("lat_default", 0, 64'(n), 64'd65);
        chk("resp_all_ones", 0, 64'(rsp[0]), 64'hFFFF);
        chk("nibble_order", 0, nibs, 64'hFEDCBA9876543210);
        repeat (3) @(negedge clk);

        ch[0] = '0;
        sdmode = 1;
        run_seq(0, 1'b0, n);
        chk("lat_pattern", 0, 64'(n), 64'd65);
        chk("resp_pattern", 0, 64'(rsp[0]), 64'hA5C3);
        repeat (3) @(negedge clk);

        sdmode = 0;
        ch[0] = {$urandom, $urandom};
        st[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            st[0] = 1'b0;
            if (act[0] && k[0] == 9) break;
        end
        chk("abort_reach", 0, 64'(k[0]), 64'd9);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_resp", 0, 64'(rsp[0]), 64'h0003);
        chk("abort_sser", 0, 64'(so[0]), 64'h1);
        chk("abort_busy", 0, 64'(bz[0]), 64'h0);
        repeat (2) @(negedge clk);
        ch[0] = {$urandom, $urandom};
        run_seq(0, 1'b0, n);
        chk("lat_after_abort", 0, 64'(n), 64'd65);
        chk("resp_after_abort", 0, 64'(rsp[0]), 64'hFFFF);
        repeat (2) @(negedge clk);

        st[0] = 1'b1; ab[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; ab[0] = 1'b0;
        chk("start_abort_busy", 0, 64'(bz[0]), 64'h0);
        repeat (2) @(negedge clk);

        sdmode = 2;
        ch[1] = {$urandom, $urandom};
        run_seq(1, 1'b0, n);
        chk("lat_small", 1, 64'(n), 64'd9);
        repeat (2) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                ab[i] = ($urandom_range(0, 79) == 0);
                ch[i] = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0;
        end
        repeat (80) @(negedge clk);

        ch[1] = {$urandom, $urandom};
        st[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_sser", 1, 64'(so[1]), 64'h1);
        chk("rst_ba12", 1, 64'(b12[1]), 64'h0);
        chk("rst_busy", 1, 64'(bz[1]), 64'h0);
        chk("rst_done", 1, 64'(dn[1]), 64'h0);
        chk("rst_resp", 1, 64'(rsp[1]), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/key_seq_initiator.md
Name: key_seq_initiator

Overview:
- Bus-side initiator for the address-encoded serial key protocol.
- On `start` it issues SEQ_LEN qualified read cycles. Each cycle is SSER low, BA13=0, BA12=1, BR_W=1, with BA7..BA4 carrying one challenge nibble.
- It samples the responder's serial data line (SDRD) once per cycle and assembles the bits into a response word.
- Sits between the host control logic and the key-device bus pins, and produces the exact cycle stream the key decoder advances on.

Parameters:
- SEQ_LEN, 16, number of bus cycles per sequence (≥1); also the response width.
- STROBE_CYCLES, 2, clocks SSER is held low per bus cycle (≥1).
- GAP_CYCLES, 1, clocks SSER is held high between bus cycles (≥0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- abort  in  1  terminate sequence; takes priority over every other event.
- challenge  in  4*SEQ_LEN  nibble i = challenge[4i+3:4i]; latched on accepted start.
- sdrd  in  1  serial data from responder; sampled only as defined below.
- sser_n  out  1  select strobe, active low.
- ba13  out  1  address bit 13.
- ba12  out  1  address bit 12.
- ba_nib  out  4  address bits BA7..BA4.
- br_w  out  1  read/not-write; 1 = read.
- busy  out  1  high from the cycle after start acceptance until return to IDLE.
- done  out  1  one-clock pulse when a full sequence completes.
- response  out  SEQ_LEN  bit i = sdrd sample from bus cycle i.

Behaviour:
- Reset (async, immediate):
  - Outputs: sser_n=1, ba13=0, ba12=0, ba_nib=0, br_w=0, busy=0, done=0, response=0.
  - Internal: state=IDLE, index=0, latched challenge=0.
- Registered outputs: all outputs are registers; no combinational path from inputs to outputs.
- State IDLE:
  - Bus pins parked: sser_n=1, ba12=0, br_w=0. The responder therefore never decodes a cycle while idle.
  - On start=1 and abort=0:
    - latch challenge;
    - clear response and index;
    - go to SETUP.
- State SETUP (1 clock):
  - sser_n=1, ba13=0, ba12=1, br_w=1, ba_nib=nibble[index].
  - Gives one clock of address setup before select.
  - Then go to STROBE with strobe counter=0.
- State STROBE (STROBE_CYCLES clocks):
  - sser_n=0; address and br_w held stable.
  - On the last strobe clock, response[index] <= sdrd, sampled at the rising edge that ends the strobe.
  - Then: if GAP_CYCLES>0 go to GAP; else if index=SEQ_LEN-1 go to FINISH; else index++ and go to SETUP.
- State GAP (GAP_CYCLES clocks):
  - sser_n=1; address held.
  - Then: if index=SEQ_LEN-1 go to FINISH; else index++ and go to SETUP.
- State FINISH (1 clock):
  - Park bus pins as in IDLE.
  - done=1 for exactly this clock; busy falls with the return to IDLE.
- Latency per sequence: SEQ_LEN*(1+STROBE_CYCLES+GAP_CYCLES) + 1 clocks from start acceptance to the done pulse.
  - Defaults: 16*4+1 = 65.
- Address stability: ba_nib, ba12, br_w never change while sser_n=0.
  - Any address change coincides with SETUP entry, when sser_n=1.
- Counter widths:
  - index uses clog2(SEQ_LEN) bits, minimum 1.
  - Strobe/gap counters use clog2(max) bits.
  - No wrap: index never exceeds SEQ_LEN-1.
- start while busy: ignored; the latched challenge is unaffected by input changes.
- abort in any non-IDLE state:
  - next clock sser_n=1 and bus parked;
  - go to IDLE; done not pulsed;
  - response keeps the bits captured so far.
- Simultaneous start and abort in IDLE: abort wins; nothing starts.
- sdrd: ignored outside the sample edge; X/Z on sdrd at other times has no effect.
- rst asserted mid-sequence: bus parks asynchronously (sser_n=1 within the same clock); all state cleared.

Test Plan:
- Reset then idle 10 clocks -> sser_n=1, ba12=0, br_w=0, busy=0, response=0 throughout.
- Default parameters, challenge = 0x0123456789ABCDEF, sdrd tied 1 -> 16 SETUP/STROBE/GAP groups. ba_nib sequence is F,E,D,...,0 (nibble0=F first). Each sser_n low window is exactly 2 clocks, with address stable across it. done pulses at clock 65 after start; response=0xFFFF.
- sdrd driven from a model returning the pattern 0xA5C3, LSB first, with challenge=0 -> response=0xA5C3 at done; every cycle shows ba13=0, ba12=1, br_w=1.
- abort asserted during the 3rd STROBE -> sser_n=1 next clock; IDLE; no done; response[1:0] holds the captured bits and higher bits=0; a following start runs a full fresh sequence.
- start pulsed again at clock 20 of a sequence and the challenge input changed mid-run -> no restart; nibbles match the originally latched value; done still at clock 65.
- GAP_CYCLES=0, STROBE_CYCLES=1, SEQ_LEN=4 -> sser_n high 1 clock between strobes; done at clock 9; rst asserted at clock 5 -> sser_n=1 immediately and all outputs at reset values.
